// File: rtl/processing_unit.sv
// 2x2 block matrix multiply-accumulate unit: loads A and B from a register file, then C += A*B.
// Define PU_SATURATE_EN to make every accumulate saturate instead of wrapping.
module processing_unit #(
  parameter int DATA_W  = 32,
  parameter int BLOCK_N = 2
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_PU_Start,
  input  logic                  i_Clear_Acc,
  output logic [1:0]            o_RF_Address,
  output logic                  o_AorB,
  output logic                  o_RF_Read_Enable,
  input  logic [DATA_W-1:0]     i_RF_Data,
  output logic [4*DATA_W-1:0]   o_Result,
  output logic                  o_Partial_Output_Ready,
  output logic                  o_Busy
);

  localparam int N_ELEM = BLOCK_N * BLOCK_N;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MAC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [3:0]        cnt_q;
  logic              clear_q;
  logic [DATA_W-1:0] a_q [N_ELEM];
  logic [DATA_W-1:0] b_q [N_ELEM];
  logic [DATA_W-1:0] c_q [N_ELEM];

  logic [2:0]        cap_idx;
  logic [1:0]        a_idx, b_idx, c_idx;
  logic [DATA_W-1:0] product;
  logic [DATA_W-1:0] acc_sum;

  function automatic logic [DATA_W-1:0] acc_add(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
    logic [DATA_W-1:0] s;
    s = x + y;
`ifdef PU_SATURATE_EN
    if ((x[DATA_W-1] == y[DATA_W-1]) && (s[DATA_W-1] != x[DATA_W-1])) begin
      s = x[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
`endif
    return s;
  endfunction

  // MAC step order is (i,j,k) taken straight from the counter bits.
  assign a_idx = {cnt_q[2], cnt_q[0]};
  assign b_idx = {cnt_q[0], cnt_q[1]};
  assign c_idx = {cnt_q[2], cnt_q[1]};

  // The low DATA_W bits of a signed product equal those of a plain DATA_W-wide multiply.
  assign product = a_q[a_idx] * b_q[b_idx];
  assign acc_sum = acc_add(c_q[c_idx], product);

  // Read data arrives one cycle after its address, so capture lags the read counter by one.
  assign cap_idx = 3'(cnt_q - 4'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_PU_Start) state_d = LOAD;
      LOAD: if (cnt_q == 4'd8) state_d = MAC;
      MAC:  if (cnt_q == 4'd7) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_RF_Read_Enable       = 1'b0;
    o_RF_Address           = 2'd0;
    o_AorB                 = 1'b0;
    o_Partial_Output_Ready = 1'b0;
    o_Busy                 = (state_q != IDLE);
    if (state_q == LOAD && cnt_q < 4'd8) begin
      o_RF_Read_Enable = 1'b1;
      o_RF_Address     = cnt_q[1:0];
      o_AorB           = cnt_q[2];
    end
    if (state_q == DONE) o_Partial_Output_Ready = 1'b1;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      clear_q <= 1'b0;
      for (int e = 0; e < N_ELEM; e++) begin
        a_q[e] <= '0;
        b_q[e] <= '0;
        c_q[e] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;
      if (state_q == IDLE && i_PU_Start) clear_q <= i_Clear_Acc;
      if (state_q == LOAD) begin
        if (cnt_q == 4'd0 && clear_q) begin
          for (int e = 0; e < N_ELEM; e++) c_q[e] <= '0;
        end
        if (cnt_q != 4'd0) begin
          if (cap_idx[2]) b_q[cap_idx[1:0]] <= i_RF_Data;
          else            a_q[cap_idx[1:0]] <= i_RF_Data;
        end
      end
      if (state_q == MAC) c_q[c_idx] <= acc_sum;
    end
  end

  assign o_Result = {c_q[3], c_q[2], c_q[1], c_q[0]};

endmodule

// File: tb/tb_processing_unit.sv
// Self-checking bench for processing_unit: a run-level reference model checked every cycle,
// plus directed block tests with hand-computed results (PU_SATURATE_EN aware).
module tb_processing_unit;

  localparam int DW = 32;

  logic          i_Clock = 1'b0;
  logic          i_Reset = 1'b1;
  logic          i_PU_Start = 1'b0;
  logic          i_Clear_Acc = 1'b0;
  logic [1:0]    o_RF_Address;
  logic          o_AorB;
  logic          o_RF_Read_Enable;
  logic [DW-1:0] i_RF_Data = '0;
  logic [4*DW-1:0] o_Result;
  logic          o_Partial_Output_Ready;
  logic          o_Busy;

  processing_unit #(.DATA_W(DW), .BLOCK_N(2)) dut (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .i_PU_Start(i_PU_Start),
    .i_Clear_Acc(i_Clear_Acc),
    .o_RF_Address(o_RF_Address),
    .o_AorB(o_AorB),
    .o_RF_Read_Enable(o_RF_Read_Enable),
    .i_RF_Data(i_RF_Data),
    .o_Result(o_Result),
    .o_Partial_Output_Ready(o_Partial_Output_Ready),
    .o_Busy(o_Busy)
  );

  always #5 i_Clock = ~i_Clock;

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  logic [DW-1:0] rf_a [4] = '{default: '0};
  logic [DW-1:0] rf_b [4] = '{default: '0};

  // Register file: data for a read appears on the following cycle.
  always @(posedge i_Clock)
    i_RF_Data <= o_RF_Read_Enable ? (o_AorB ? rf_b[o_RF_Address] : rf_a[o_RF_Address]) : '0;

  task automatic checkOutput(input string name, input logic [4*DW-1:0] actual,
                             input logic [4*DW-1:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [DW-1:0] addAcc(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic signed [63:0] s;
    logic signed [DW-1:0] sx, sy;
    sx = x;
    sy = y;
    s = 64'(sx) + 64'(sy);
`ifdef PU_SATURATE_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[DW-1:0];
  endfunction

  // Run-level model: t counts cycles since the start edge (0 = idle); results land in cycle 18.
  int            t = 0;
  logic [DW-1:0] m_c [4] = '{default: '0};
  logic [DW-1:0] m_next [4];

  always @(posedge i_Clock) begin
    if (i_Reset) begin
      t = 0;
      m_c = '{default: '0};
    end else if (t == 0) begin
      if (i_PU_Start) begin
        t = 1;
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++) begin
            logic [DW-1:0] acc;
            acc = i_Clear_Acc ? '0 : m_c[i*2+j];
            for (int k = 0; k < 2; k++) begin
              logic signed [DW-1:0] sa, sb;
              logic signed [63:0] p;
              sa = rf_a[i*2+k];
              sb = rf_b[k*2+j];
              p = sa * sb;
              acc = addAcc(acc, p[DW-1:0]);
            end
            m_next[i*2+j] = acc;
          end
      end
    end else if (t == 18) begin
      t = 0;
    end else begin
      t = t + 1;
      if (t == 18) m_c = m_next;
    end
  end

  always @(negedge i_Clock) begin
    if (check_en) begin
      checkOutput("busy", 128'(o_Busy), 128'(t != 0));
      checkOutput("read_en", 128'(o_RF_Read_Enable), 128'(t >= 1 && t <= 8));
      checkOutput("aorb", 128'(o_AorB), 128'(t >= 5 && t <= 8));
      checkOutput("rf_addr", 128'(o_RF_Address), (t >= 1 && t <= 8) ? 128'((t - 1) % 4) : 128'd0);
      checkOutput("ready", 128'(o_Partial_Output_Ready), 128'(t == 18));
      if (t == 0 || t == 18)
        checkOutput("result_model", o_Result, {m_c[3], m_c[2], m_c[1], m_c[0]});
    end
  end

  task automatic loadBlocks(input logic [DW-1:0] a0, a1, a2, a3, b0, b1, b2, b3);
    rf_a = '{a0, a1, a2, a3};
    rf_b = '{b0, b1, b2, b3};
  endtask

  // Pulses start for one cycle; returns just after the negedge of cycle 1 of the run.
  task automatic applyStimulus(input logic clr);
    @(negedge i_Clock);
    #1;
    i_Clear_Acc = clr;
    i_PU_Start  = 1'b1;
    @(negedge i_Clock);
    #1;
    i_PU_Start = 1'b0;
  endtask

  // Called from cycle 1; reports the cycle number of the pulse, or -1 on timeout.
  task automatic waitPulse(output int lat);
    lat = -1;
    for (int n = 2; n <= 40; n++) begin
      @(negedge i_Clock);
      if (o_Partial_Output_Ready) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic runBlock(input string name, input logic clr, input logic [4*DW-1:0] expected);
    int lat;
    applyStimulus(clr);
    waitPulse(lat);
    checkOutput({name, "_latency"}, 128'(lat), 128'd18);
    checkOutput({name, "_result"}, o_Result, expected);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [4*DW-1:0] exp_ovf, exp_sat;

    repeat (2) @(negedge i_Clock);
    check_en = 1'b1;
    checkOutput("reset_result", o_Result, '0);
    checkOutput("reset_busy", 128'(o_Busy), 128'd0);
    checkOutput("reset_read_en", 128'(o_RF_Read_Enable), 128'd0);
    #1;
    i_Reset = 1'b0;

    loadBlocks(1, 0, 0, 1, 5, 6, 7, 8);
    runBlock("identity", 1'b1, {32'd8, 32'd7, 32'd6, 32'd5});
    runBlock("accumulate", 1'b0, {32'd16, 32'd14, 32'd12, 32'd10});
    runBlock("reclear", 1'b1, {32'd8, 32'd7, 32'd6, 32'd5});

    loadBlocks(32'hFFFF_FFFD, 4, 2, 32'hFFFF_FFFF, 7, 32'hFFFF_FFFE, 5, 3);
    runBlock("signed", 1'b1, {32'hFFFF_FFF9, 32'd9, 32'd18, 32'hFFFF_FFFF});

    // 0x7FFFFFFF*2 truncates to -2, which then adds to zero without overflow in either mode.
    exp_ovf = {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFE};
    loadBlocks(32'h7FFF_FFFF, 0, 0, 0, 2, 0, 0, 0);
    runBlock("overflow", 1'b1, exp_ovf);

    loadBlocks(32'h7FFF_FFF0, 0, 0, 0, 1, 0, 0, 0);
    runBlock("sat_preload", 1'b1, {96'd0, 32'h7FFF_FFF0});
`ifdef PU_SATURATE_EN
    exp_sat = {96'd0, 32'h7FFF_FFFF};
`else
    exp_sat = {96'd0, 32'h8000_0000};
`endif
    loadBlocks(16, 0, 0, 0, 1, 0, 0, 0);
    runBlock("saturate", 1'b0, exp_sat);

    // Reset sampled at the end of the 5th LOAD cycle.
    loadBlocks(1, 0, 0, 1, 5, 6, 7, 8);
    applyStimulus(1'b0);
    repeat (4) @(negedge i_Clock);
    #1;
    i_Reset = 1'b1;
    @(negedge i_Clock);
    #1;
    i_Reset = 1'b0;
    checkOutput("abort_result", o_Result, '0);
    checkOutput("abort_busy", 128'(o_Busy), 128'd0);
    checkOutput("abort_read_en", 128'(o_RF_Read_Enable), 128'd0);
    pulses = 0;
    repeat (25) begin
      @(negedge i_Clock);
      if (o_Partial_Output_Ready) pulses++;
    end
    checkOutput("abort_no_pulse", 128'(pulses), 128'd0);

    // A start request in MAC must be ignored.
    applyStimulus(1'b1);
    repeat (11) @(negedge i_Clock);
    #1;
    i_PU_Start = 1'b1;
    @(negedge i_Clock);
    #1;
    i_PU_Start = 1'b0;
    pulses = 0;
    repeat (35) begin
      @(negedge i_Clock);
      if (o_Partial_Output_Ready) pulses++;
    end
    checkOutput("busy_one_pulse", 128'(pulses), 128'd1);
    checkOutput("busy_result", o_Result, {32'd8, 32'd7, 32'd6, 32'd5});

    // Start held high through DONE relaunches on the first IDLE cycle.
    @(negedge i_Clock);
    #1;
    i_Clear_Acc = 1'b1;
    i_PU_Start  = 1'b1;
    @(negedge i_Clock);
    waitPulse(lat);
    checkOutput("held_first_latency", 128'(lat), 128'd18);
    @(negedge i_Clock);
    @(negedge i_Clock);
    #1;
    i_PU_Start = 1'b0;
    lat = -1;
    for (int n = 3; n <= 40; n++) begin
      @(negedge i_Clock);
      if (o_Partial_Output_Ready) begin
        lat = n;
        break;
      end
    end
    checkOutput("held_restart_gap", 128'(lat), 128'd19);

    repeat (5) @(negedge i_Clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/processing_unit.md
PROCESSING_UNIT -- requirements
Module: processing_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each matrix element and accumulator.
REQ-002 SHALL have parameter BLOCK_N, fixed at 2, block dimension; other values are unsupported.
REQ-003 SHALL use a single clock and a synchronous, active-high reset.
REQ-004 Ports SHALL be as listed below (name, direction, width, meaning):
- i_Clock  in  1  sole clock; all state updates on its rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_PU_Start  in  1  start request from the control unit.
- i_Clear_Acc  in  1  sampled with i_PU_Start; 1 means start from C=0, 0 means add to the held C.
- o_RF_Address  out  2  register-file element index, row-major (a00, a01, a10, a11).
- o_AorB  out  1  0 selects the A block file, 1 selects the B block file.
- o_RF_Read_Enable  out  1  read strobe; data returns exactly one cycle later.
- i_RF_Data  in  DATA_W  signed read data.
- o_Result  out  4*DATA_W  C block, c00 in LSBs, then c01, c10, c11.
- o_Partial_Output_Ready  out  1  one-cycle completion pulse.
- o_Busy  out  1  high whenever the state is not IDLE.

Function
REQ-005 The FSM SHALL have the states IDLE, LOAD, MAC and DONE.
REQ-006 IDLE SHALL move to LOAD on the edge that samples i_PU_Start=1, and SHALL latch i_Clear_Acc on that same edge.
REQ-007 LOAD SHALL assert o_RF_Read_Enable for 8 consecutive cycles: AorB=0 with addresses 0..3, then AorB=1 with addresses 0..3.
REQ-008 LOAD SHALL capture i_RF_Data one cycle after each read, and SHALL last 9 cycles in total (8 reads plus 1 capture).
REQ-009 If the latched clear is 1, LOAD SHALL zero the C registers on its first cycle.
REQ-010 MAC SHALL use one multiplier and SHALL run for 8 cycles, order (i,j,k) = 000,001,010,011,100,101,110,111.
REQ-011 Each MAC cycle SHALL perform c_ij <= c_ij + a_ik*b_kj.
REQ-012 Each product SHALL be the full 2*DATA_W signed product, truncated to the low DATA_W bits.
REQ-013 Each addition SHALL be a DATA_W two's-complement add that wraps on overflow, except as REQ-024 states.
REQ-014 DONE SHALL last 1 cycle, SHALL assert o_Partial_Output_Ready for that cycle only, and SHALL then return to IDLE.
REQ-015 Latency: o_Partial_Output_Ready SHALL be high in the 18th cycle after the start-sampling edge (9 LOAD cycles + 8 MAC cycles + DONE).
REQ-016 o_Result SHALL be driven from the C registers and SHALL hold stable from DONE until the next MAC update or reset.
REQ-017 i_PU_Start SHALL be ignored when the state is not IDLE.
REQ-018 If i_PU_Start is held high through DONE, a new run SHALL start on the first IDLE cycle.
REQ-019 o_RF_Read_Enable SHALL be 0 outside LOAD; o_RF_Address and o_AorB SHALL be 0 when no read is issued.

Reset
REQ-020 Reset SHALL put the FSM in IDLE and SHALL clear the A, B and C registers, the latched clear, o_Result, o_RF_*, o_AorB, o_Busy and o_Partial_Output_Ready to 0.
REQ-021 Reset asserted in any state, including mid-LOAD or mid-MAC, SHALL abort the run and SHALL NOT produce a pulse.
REQ-022 Reset SHALL take priority over i_PU_Start on the same edge.

Configuration
REQ-023 Macro PU_SATURATE_EN SHALL select the addition mode.
REQ-024 With PU_SATURATE_EN defined, each accumulate SHALL saturate to the signed DATA_W maximum or minimum on overflow.
REQ-025 With PU_SATURATE_EN undefined, accumulation SHALL wrap.
REQ-026 Product truncation SHALL be identical in both modes.

Verification
REQ-027 Identity test: A={1,0,0,1}, B={5,6,7,8}, clear=1 -> o_Result={5,6,7,8}, with the pulse exactly 18 cycles after the start edge.
REQ-028 Accumulation test: repeat REQ-027 with clear=0 -> {10,12,14,16}; then with clear=1 -> {5,6,7,8}.
REQ-029 Overflow test: A={32'h7FFFFFFF,0,0,0}, B={2,0,0,0}, clear=1 -> c00=32'hFFFFFFFE without the macro; with PU_SATURATE_EN, c00 per REQ-012/REQ-024.
REQ-030 Saturation test: with PU_SATURATE_EN, start c00=32'h7FFFFFF0, then A={16,0,0,0}, B={1,0,0,0}, clear=0 -> c00=32'h7FFFFFFF.
REQ-031 Reset test: reset in the 5th LOAD cycle -> IDLE on the next edge, o_Result=0, no pulse, o_RF_Read_Enable=0.
REQ-032 Busy test: a start pulse during MAC -> ignored, exactly one pulse, o_Busy=1 from the cycle after the start edge through DONE.
